demux_steer_ctrl: RTL and testbench

//  Buffered steering controller for the 16-bit 1:2 demux datapath. Accepts
//  {sel,data} words from the execute/writeback stage over a valid/ready

---
 rtl/demux_steer_ctrl.sv | 117 +++++++++++
 tb/tb_demux_steer_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/demux_steer_ctrl.sv
// Buffered 1:2 steering controller: FIFO of {sel,data} words, head presented to one destination.
// Optional per-destination delivery counters are built when DEMUX_STATS_EN is defined.
module demux_steer_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]       count0,
  output logic [15:0]       count1
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_PARTIAL = 2'd1;
  localparam logic [1:0] ST_FULL    = 2'd2;

  localparam logic [PTR_W:0]   OCC_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   OCC_FULL = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [DATA_W:0]   mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    occ;
  logic [DATA_W-1:0] hold_data;
  logic [1:0]        state;
  logic [DATA_W:0]   head;
  logic              head_sel;
  logic              nonempty;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] head_data;

  always_comb begin
    state = ST_PARTIAL;
    if (occ == '0)
      state = ST_EMPTY;
    else if (occ == OCC_FULL)
      state = ST_FULL;
  end

  assign head      = mem[rd_ptr];
  assign head_sel  = head[DATA_W];
  assign nonempty  = (state != ST_EMPTY);
  assign in_ready  = (state != ST_FULL);

  assign out0_valid = nonempty & ~head_sel;
  assign out1_valid = nonempty &  head_sel;

  assign push = in_valid & in_ready;
  assign pop  = (out0_valid & out0_ready) | (out1_valid & out1_ready);

  // When empty the data ports keep showing the last word handed out, not a stale slot.
  assign head_data = nonempty ? head[DATA_W-1:0] : hold_data;
  assign out0_data = head_data;
  assign out1_data = head_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occ       <= '0;
      hold_data <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_sel, in_data};
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        hold_data <= head[DATA_W-1:0];
      end
      if (push && !pop)
        occ <= occ + OCC_ONE;
      else if (pop && !push)
        occ <= occ - OCC_ONE;
    end
  end

`ifdef DEMUX_STATS_EN
  // Flush discards the same-cycle pop, so it is not counted as a delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count0 <= '0;
      count1 <= '0;
    end else if (!flush) begin
      if (out0_valid && out0_ready && (count0 != '1))
        count0 <= count0 + 16'd1;
      if (out1_valid && out1_ready && (count1 != '1))
        count1 <= count1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_steer_ctrl.sv
// Scoreboard bench for demux_steer_ctrl: directed scenarios plus random traffic vs. a queue model.
module tb_demux_steer_ctrl;

  localparam int DEPTH = 2;

  typedef struct {
    logic        sel;
    logic [15:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sel = 1'b0;
  logic [15:0] in_data = '0;
  logic        out0_valid;
  logic        out0_ready = 1'b0;
  logic [15:0] out0_data;
  logic        out1_valid;
  logic        out1_ready = 1'b0;
  logic [15:0] out1_data;
`ifdef DEMUX_STATS_EN
  logic [15:0] count0;
  logic [15:0] count1;
`endif

  int tests = 0;
  int fails = 0;
  bit acc   = 1'b0;

  demux_steer_ctrl #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data)
`ifdef DEMUX_STATS_EN
    , .count0(count0), .count1(count1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d,
                       input logic r0, input logic r1, input logic f);
    @(negedge clk);
    in_valid = v; in_sel = s; in_data = d;
    out0_ready = r0; out1_ready = r1; flush = f;
  endtask

  // Monitor: samples just after the falling edge, when this cycle's inputs are settled.
  initial begin
    ent_t q[$];
    ent_t e;
    logic [15:0] last;
    int c0, c1;
    bit full, popped;
    last = '0; c0 = 0; c1 = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        q.delete(); last = '0; c0 = 0; c1 = 0; acc = 1'b0;
        continue;
      end
      chk("both_valid", {31'd0, out0_valid & out1_valid}, 32'd0);
      chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < DEPTH});
      if (q.size() > 0) begin
        chk("out0_valid", {31'd0, out0_valid}, {31'd0, !q[0].sel});
        chk("out1_valid", {31'd0, out1_valid}, {31'd0, q[0].sel});
        chk("out0_data", {16'd0, out0_data}, {16'd0, q[0].data});
        chk("out1_data", {16'd0, out1_data}, {16'd0, q[0].data});
      end else begin
        chk("idle_valid0", {31'd0, out0_valid}, 32'd0);
        chk("idle_valid1", {31'd0, out1_valid}, 32'd0);
        chk("idle_data0", {16'd0, out0_data}, {16'd0, last});
        chk("idle_data1", {16'd0, out1_data}, {16'd0, last});
      end
`ifdef DEMUX_STATS_EN
      chk("count0", {16'd0, count0}, c0);
      chk("count1", {16'd0, count1}, c1);
`endif
      acc = 1'b0;
      if (flush) begin
        q.delete();
      end else begin
        full   = (q.size() == DEPTH);
        popped = (q.size() > 0) && (q[0].sel ? out1_ready : out0_ready);
        if (popped) begin
          e = q.pop_front();
          last = e.data;
          if (e.sel) begin if (c1 < 65535) c1++; end
          else begin if (c0 < 65535) c0++; end
        end
        if (in_valid && !full) begin
          e.sel = in_sel; e.data = in_data;
          q.push_back(e);
          acc = 1'b1;
        end
      end
    end
  end

  initial begin
    repeat (2) drive(0, 0, 16'h0, 1, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_data0", {16'd0, out0_data}, 32'd0);

    // Steering order
    drive(1, 0, 16'hA5A5, 1, 1, 0);
    drive(1, 1, 16'h5A5A, 1, 1, 0);
    repeat (3) drive(0, 0, 16'h0, 1, 1, 0);

    // Back-pressure on dest 1 with a full queue
    drive(1, 1, 16'h1111, 1, 0, 0);
    drive(1, 1, 16'h2222, 1, 0, 0);
    drive(1, 1, 16'h3333, 1, 0, 0);
    #1 chk("T3_full_ready", {31'd0, in_ready}, 32'd0);
    drive(1, 1, 16'h3333, 1, 0, 0);
    drive(1, 1, 16'h3333, 1, 1, 0);
    drive(1, 1, 16'h3333, 1, 1, 0);
    repeat (3) drive(0, 0, 16'h0, 1, 1, 0);

    // Head-of-line blocking
    drive(1, 0, 16'hAAAA, 0, 1, 0);
    drive(1, 1, 16'hBBBB, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 16'h0, 0, 1, 0);
      #1 chk("T4_hol_out1", {31'd0, out1_valid}, 32'd0);
    end
    repeat (3) drive(0, 0, 16'h0, 1, 1, 0);

    // Flush of a full queue with a simultaneous push
    drive(1, 0, 16'hC001, 0, 0, 0);
    drive(1, 1, 16'hC002, 0, 0, 0);
    drive(1, 0, 16'hC003, 1, 1, 1);
    drive(0, 0, 16'h0, 1, 1, 0);
    #1;
    chk("T5_ready", {31'd0, in_ready}, 32'd1);
    chk("T5_valid", {30'd0, out1_valid, out0_valid}, 32'd0);

    // Async reset mid-stream
    drive(1, 0, 16'hD001, 0, 0, 0);
    drive(1, 1, 16'hD002, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("T1_valid", {30'd0, out1_valid, out0_valid}, 32'd0);
    chk("T1_data", {out1_data, out0_data}, 32'd0);
    chk("T1_ready", {31'd0, in_ready}, 32'd1);
    drive(0, 0, 16'h0, 1, 1, 0);
    drive(0, 0, 16'h0, 1, 1, 0);
    rst_n = 1'b1;

    // Random traffic; upstream holds an unaccepted word
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!(in_valid && !acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 40) == 0);
    end
    drive(0, 0, 16'h0, 1, 1, 0);
    repeat (4) drive(0, 0, 16'h0, 1, 1, 0);

`ifdef DEMUX_STATS_EN
    // Counter saturation on dest 0
    @(negedge clk); rst_n = 1'b0;
    drive(0, 0, 16'h0, 1, 1, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 70010; i++)
      drive(1, 0, 16'($urandom), 1, 1, 0);
    drive(0, 0, 16'h0, 1, 1, 0);
    drive(0, 0, 16'h0, 1, 1, 0);
    #1;
    chk("T6_count0", {16'd0, count0}, 32'h0000FFFF);
    chk("T6_count1", {16'd0, count1}, 32'd0);
`endif

    repeat (2) drive(0, 0, 16'h0, 1, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
